// File: rtl/csi_unpacket_nlane_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : csi_pkg                                                    |
// | Shared CSI-2 data-type codes, header geometry and unpacker states.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package csi_pkg;

  // CSI-2 data-type codes used by the unpacker
  localparam logic [7:0] DT_FS    = 8'h00;
  localparam logic [7:0] DT_FE    = 8'h01;
  localparam logic [7:0] DT_LS    = 8'h02;
  localparam logic [7:0] DT_LE    = 8'h03;
  localparam logic [7:0] DT_RAW8  = 8'h2A;
  localparam logic [7:0] DT_RAW10 = 8'h2B;
  localparam logic [7:0] DT_RAW12 = 8'h2C;

  // Data types 0x00..0x0F are short packets (no payload)
  localparam logic [7:0] DT_SHORT_MAX = 8'h0F;

  // Packet header is always four bytes: {DI, WC_L, WC_H, ECC}
  localparam int HDR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/csi_unpacket_nlane_hdr_collect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : csi_hdr_collect                                            |
// | Start-of-packet detect, multi-word header assembly and field split.  |
// | The fields reflect the header including the current input word, so  |
// | the parent can decode in the same cycle the last word arrives.       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module csi_hdr_collect
  import csi_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hs_valid_i,
  input  logic [8*LANES-1:0] hs_data_i,
  input  logic               collect_i,   // current word belongs to the header
  output logic               sop_o,
  output logic               hdr_done_o,  // current word completes the header
  output logic [1:0]         vc_o,
  output logic [7:0]         dt_o,
  output logic [15:0]        wc_o
);

  localparam int         DW        = 8 * LANES;
  localparam int         HDR_WORDS = HDR_BYTES / LANES;
  localparam logic [1:0] LAST_IDX  = 2'(HDR_WORDS - 1);

  logic        valid_1d_q;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_eff;
  logic [31:0] hdr_next;
  logic        w_unused_ecc;

  // Previous-cycle valid; tracked through reset so that a packet already
  // in flight when reset releases is not mistaken for a new one.
  always_ff @(posedge clk_i) begin
    valid_1d_q <= hs_valid_i;
  end

  assign sop_o      = hs_valid_i & ~valid_1d_q;
  assign cnt_eff    = sop_o ? 2'd0 : cnt_q;
  assign hdr_done_o = collect_i & (cnt_eff == LAST_IDX);

  // Header word counter, restarted by every start of packet
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
    end else if (collect_i) begin
      cnt_q <= hdr_done_o ? 2'd0 : cnt_eff + 2'd1;
    end
  end

  generate
    if (DW >= 32) begin : g_full
      // One word carries the whole header; no storage needed
      assign hdr_next = hs_data_i[31:0];
    end else begin : g_shift
      logic [31-DW:0] hdr_q;

      assign hdr_next = {hdr_q, hs_data_i};

      // Earlier header bytes, shifted MSB-first
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          hdr_q <= '0;
        end else if (collect_i) begin
          hdr_q <= hdr_next[31-DW:0];
        end
      end
    end
  endgenerate

  assign vc_o         = hdr_next[31:30];
  assign dt_o         = {2'b00, hdr_next[29:24]};
  assign wc_o         = {hdr_next[15:8], hdr_next[23:16]};
  assign w_unused_ecc = ^hdr_next[7:0];

endmodule
`default_nettype wire

// File: rtl/csi_unpacket_nlane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : csi_unpacket_nlane                                         |
// | 1/2/4-lane CSI-2 packet unpacker: decodes short packets and forwards |
// | long-packet payload of one data type as a byte-enabled stream.       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module csi_unpacket_nlane
  import csi_pkg::*;
#(
  parameter int         LANES   = 4,
  parameter logic [7:0] DATA_DT = DT_RAW10
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_hs_valid,
  input  logic [8*LANES-1:0] I_hs_data,
  input  logic [3:0]         I_vc_mask,
  output logic               O_csi_frame_start,
  output logic               O_csi_frame_end,
  output logic               O_line_start,
  output logic               O_line_end,
  output logic [15:0]        O_frame_num,
  output logic [1:0]         O_vc,
  output logic               O_csi_valid,
  output logic [8*LANES-1:0] O_csi_data,
  output logic [LANES-1:0]   O_csi_keep,
  output logic               O_csi_last,
  output logic               O_err_short
);

  localparam int          DW        = 8 * LANES;
  localparam logic [16:0] LANES_REM = 17'(LANES);

  state_e          state_q, state_d;
  logic [16:0]     rem_q, rem_d;
  logic            fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic [15:0]     frame_num_q, frame_num_d;
  logic [1:0]      vc_q, vc_d;
  logic            valid_q, valid_d, last_q, last_d, err_q, err_d;
  logic [DW-1:0]   data_q, data_d, tail_data;
  logic [LANES-1:0] keep_q, keep_d, tail_keep;

  logic            sop, collect, hdr_done;
  logic [1:0]      hdr_vc;
  logic [7:0]      hdr_dt;
  logic [15:0]     hdr_wc;

  assign collect = ((state_q == IDLE) & sop) | ((state_q == HDR) & I_hs_valid);

  csi_hdr_collect #(
    .LANES (LANES)
  ) u_hdr (
    .clk_i      (I_clk),
    .rst_i      (I_rst),
    .hs_valid_i (I_hs_valid),
    .hs_data_i  (I_hs_data),
    .collect_i  (collect),
    .sop_o      (sop),
    .hdr_done_o (hdr_done),
    .vc_o       (hdr_vc),
    .dt_o       (hdr_dt),
    .wc_o       (hdr_wc)
  );

  // Final-word byte enable: the earliest rem bytes (top lanes) survive
  always_comb begin
    tail_keep = '0;
    tail_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rem_q > 17'(LANES - 1 - i)) begin
        tail_keep[i]       = 1'b1;
        tail_data[8*i +: 8] = I_hs_data[8*i +: 8];
      end
    end
  end

  // Next-state and registered-output logic; header decode overrides state
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    ls_d        = 1'b0;
    le_d        = 1'b0;
    frame_num_d = frame_num_q;
    vc_d        = vc_q;
    valid_d     = 1'b0;
    data_d      = '0;
    keep_d      = '0;
    last_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (sop) state_d = HDR;
      end
      HDR: begin
        if (!I_hs_valid) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      PAYLOAD: begin
        if (I_hs_valid) begin
          valid_d = 1'b1;
          if (rem_q > LANES_REM) begin
            keep_d = '1;
            data_d = I_hs_data;
            rem_d  = rem_q - LANES_REM;
          end else begin
            keep_d  = tail_keep;
            data_d  = tail_data;
            last_d  = 1'b1;
            rem_d   = '0;
            state_d = DRAIN;
          end
        end else begin
          // Packet ended with payload still owed
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!I_hs_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (hdr_done) begin
      if (!I_vc_mask[hdr_vc]) begin
        state_d = DRAIN;
      end else if (hdr_dt <= DT_SHORT_MAX) begin
        fs_d = (hdr_dt == DT_FS);
        fe_d = (hdr_dt == DT_FE);
        ls_d = (hdr_dt == DT_LS);
        le_d = (hdr_dt == DT_LE);
        if (hdr_dt == DT_FS) begin
          frame_num_d = hdr_wc;
          vc_d        = hdr_vc;
        end
        state_d = DRAIN;
      end else if ((hdr_dt == DATA_DT) && (hdr_wc != 16'd0)) begin
        vc_d    = hdr_vc;
        rem_d   = {1'b0, hdr_wc};
        state_d = PAYLOAD;
      end else begin
        state_d = DRAIN;
      end
    end
  end

  // State, counter and output registers
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ls_q        <= 1'b0;
      le_q        <= 1'b0;
      frame_num_q <= '0;
      vc_q        <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ls_q        <= ls_d;
      le_q        <= le_d;
      frame_num_q <= frame_num_d;
      vc_q        <= vc_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  assign O_csi_frame_start = fs_q;
  assign O_csi_frame_end   = fe_q;
  assign O_line_start      = ls_q;
  assign O_line_end        = le_q;
  assign O_frame_num       = frame_num_q;
  assign O_vc              = vc_q;
  assign O_csi_valid       = valid_q;
  assign O_csi_data        = data_q;
  assign O_csi_keep        = keep_q;
  assign O_csi_last        = last_q;
  assign O_err_short       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_csi_unpacket_nlane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_csi_unpacket_nlane                                      |
// | Directed bench for the 4-, 2- and 1-lane unpacker configurations.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_csi_unpacket_nlane;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-lane instance
  logic        v4 = 1'b0;
  logic [31:0] d4 = '0;
  logic [3:0]  m4 = 4'hF;
  logic        fs4, fe4, ls4, le4, cv4, cl4, er4;
  logic [15:0] fn4;
  logic [1:0]  vc4;
  logic [31:0] cd4;
  logic [3:0]  ck4;

  // 2-lane instance
  logic        v2 = 1'b0;
  logic [15:0] d2 = '0;
  logic [3:0]  m2 = 4'hF;
  logic        fs2, fe2, ls2, le2, cv2, cl2, er2;
  logic [15:0] fn2;
  logic [1:0]  vc2;
  logic [15:0] cd2;
  logic [1:0]  ck2;

  // 1-lane instance
  logic        v1 = 1'b0;
  logic [7:0]  d1 = '0;
  logic [3:0]  m1 = 4'hF;
  logic        fs1, fe1, ls1, le1, cv1, cl1, er1;
  logic [15:0] fn1;
  logic [1:0]  vc1;
  logic [7:0]  cd1;
  logic [0:0]  ck1;

  csi_unpacket_nlane #(.LANES(4), .DATA_DT(8'h2B)) dut4 (
    .I_clk(clk), .I_rst(rst), .I_hs_valid(v4), .I_hs_data(d4), .I_vc_mask(m4),
    .O_csi_frame_start(fs4), .O_csi_frame_end(fe4), .O_line_start(ls4),
    .O_line_end(le4), .O_frame_num(fn4), .O_vc(vc4), .O_csi_valid(cv4),
    .O_csi_data(cd4), .O_csi_keep(ck4), .O_csi_last(cl4), .O_err_short(er4)
  );

  csi_unpacket_nlane #(.LANES(2), .DATA_DT(8'h2B)) dut2 (
    .I_clk(clk), .I_rst(rst), .I_hs_valid(v2), .I_hs_data(d2), .I_vc_mask(m2),
    .O_csi_frame_start(fs2), .O_csi_frame_end(fe2), .O_line_start(ls2),
    .O_line_end(le2), .O_frame_num(fn2), .O_vc(vc2), .O_csi_valid(cv2),
    .O_csi_data(cd2), .O_csi_keep(ck2), .O_csi_last(cl2), .O_err_short(er2)
  );

  csi_unpacket_nlane #(.LANES(1), .DATA_DT(8'h2B)) dut1 (
    .I_clk(clk), .I_rst(rst), .I_hs_valid(v1), .I_hs_data(d1), .I_vc_mask(m1),
    .O_csi_frame_start(fs1), .O_csi_frame_end(fe1), .O_line_start(ls1),
    .O_line_end(le1), .O_frame_num(fn1), .O_vc(vc1), .O_csi_valid(cv1),
    .O_csi_data(cd1), .O_csi_keep(ck1), .O_csi_last(cl1), .O_err_short(er1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // One 4-lane input word and the full output bundle expected after it
  typedef struct {
    string       name;
    logic        v;
    logic [31:0] d;
    logic [3:0]  m;
    logic [60:0] exp;  // {fs,fe,ls,le, fn, vc, valid, data, keep, last, err}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic v, input logic [31:0] d,
                     input logic [3:0] m, input logic [3:0] pul,
                     input logic [15:0] fn, input logic [1:0] vc,
                     input logic cv, input logic [31:0] cd,
                     input logic [3:0] ck, input logic cl, input logic er);
    vec_t r;
    r.name = n;
    r.v    = v;
    r.d    = d;
    r.m    = m;
    r.exp  = {pul, fn, vc, cv, cd, ck, cl, er};
    tbl.push_back(r);
  endtask

  function automatic logic [63:0] act4();
    act4 = {3'b000, fs4, fe4, ls4, le4, fn4, vc4, cv4, cd4, ck4, cl4, er4};
  endfunction

  function automatic logic [63:0] act2();
    act2 = 64'({fs2, fe2, ls2, le2, fn2, vc2, cv2, cd2, ck2, cl2, er2});
  endfunction

  function automatic logic [63:0] act1();
    act1 = 64'({fs1, fe1, ls1, le1, fn1, vc1, cv1, cd1, ck1, cl1, er1});
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes[$];

    // ---------------- 4-lane vector table ----------------
    add("idle",       0, 32'h0,        4'hF, 4'b0000, 16'd0, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("fs_hdr",     1, 32'h000700EC, 4'hF, 4'b1000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("fs_drain",   1, 32'h12345678, 4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("gap0",       0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("raw10_hdr",  1, 32'h6B0A0033, 4'hF, 4'b0000, 16'd7, 2'd1, 0, 32'h0,        4'h0,    0, 0);
    add("pay0",       1, 32'hA1A2A3A4, 4'hF, 4'b0000, 16'd7, 2'd1, 1, 32'hA1A2A3A4, 4'hF,    0, 0);
    add("pay1",       1, 32'hB1B2B3B4, 4'hF, 4'b0000, 16'd7, 2'd1, 1, 32'hB1B2B3B4, 4'hF,    0, 0);
    add("pay2_last",  1, 32'hC1C2C3C4, 4'hF, 4'b0000, 16'd7, 2'd1, 1, 32'hC1C20000, 4'b1100, 1, 0);
    add("crc",        1, 32'hBEEF0000, 4'hF, 4'b0000, 16'd7, 2'd1, 0, 32'h0,        4'h0,    0, 0);
    add("gap1",       0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd1, 0, 32'h0,        4'h0,    0, 0);
    add("short_hdr",  1, 32'h2B100000, 4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("short_p0",   1, 32'h11111111, 4'hF, 4'b0000, 16'd7, 2'd0, 1, 32'h11111111, 4'hF,    0, 0);
    add("short_p1",   1, 32'h22222222, 4'hF, 4'b0000, 16'd7, 2'd0, 1, 32'h22222222, 4'hF,    0, 0);
    add("short_drop", 0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 1);
    add("b2b_le",     1, 32'h03000000, 4'hF, 4'b0001, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("gap2",       0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("ls",         1, 32'h02000000, 4'hF, 4'b0010, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("gap3",       0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("vc_masked",  1, 32'h80050000, 4'h1, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("gap4",       0, 32'h0,        4'h1, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("wc4_hdr",    1, 32'h2B040000, 4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("wc4_last",   1, 32'h55667788, 4'hF, 4'b0000, 16'd7, 2'd0, 1, 32'h55667788, 4'hF,    1, 0);
    add("wc4_fill",   1, 32'h99999999, 4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("gap5",       0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("wc0_hdr",    1, 32'h2B000000, 4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("wc0_fill",   1, 32'h77777777, 4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("gap6",       0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("fe",         1, 32'h01090000, 4'hF, 4'b0100, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("gap7",       0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("wc1_hdr",    1, 32'h2B010000, 4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("wc1_last",   1, 32'hAABBCCDD, 4'hF, 4'b0000, 16'd7, 2'd0, 1, 32'hAA000000, 4'b1000, 1, 0);
    add("gap8",       0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("ffff_hdr",   1, 32'h2BFFFF00, 4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);
    add("ffff_p0",    1, 32'h0F0F0F0F, 4'hF, 4'b0000, 16'd7, 2'd0, 1, 32'h0F0F0F0F, 4'hF,    0, 0);
    add("ffff_drop",  0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 1);
    add("gap9",       0, 32'h0,        4'hF, 4'b0000, 16'd7, 2'd0, 0, 32'h0,        4'h0,    0, 0);

    // ---------------- reset with a packet already active ----------------
    rst = 1'b1;
    v4  = 1'b1;
    d4  = 32'h000700EC;
    tick();
    tick();
    chk("reset_zero_l4", act4(), 64'(0));
    chk("reset_zero_l2", act2(), 64'(0));
    chk("reset_zero_l1", act1(), 64'(0));
    rst = 1'b0;
    tick();
    chk("no_sop_after_rst", act4(), 64'(0));

    // ---------------- 4-lane table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      v4 = tbl[i].v;
      d4 = tbl[i].d;
      m4 = tbl[i].m;
      tick();
      chk(tbl[i].name, act4(), 64'(tbl[i].exp));
    end

    // ---------------- 2-lane: split header and partial last word ----------------
    v2 = 1'b1; d2 = 16'h2B05; tick();
    chk("l2_hdr0", act2(), 64'(0));
    d2 = 16'h00AA; tick();
    chk("l2_hdr1", act2(), 64'(0));
    d2 = 16'h1122; tick();
    chk("l2_p0", 64'({cv2, cd2, ck2, cl2}), 64'({1'b1, 16'h1122, 2'b11, 1'b0}));
    d2 = 16'h3344; tick();
    chk("l2_p1", 64'({cv2, cd2, ck2, cl2}), 64'({1'b1, 16'h3344, 2'b11, 1'b0}));
    d2 = 16'h5566; tick();
    chk("l2_p2_last", 64'({cv2, cd2, ck2, cl2}), 64'({1'b1, 16'h5500, 2'b10, 1'b1}));
    d2 = 16'hCCCC; tick();
    chk("l2_crc", act2(), 64'(0));
    v2 = 1'b0; tick();
    chk("l2_gap", act2(), 64'(0));
    // header cut short after one word
    v2 = 1'b1; d2 = 16'h0000; tick();
    chk("l2_abort_hdr0", 64'({er2, fs2}), 64'(0));
    v2 = 1'b0; tick();
    chk("l2_abort_err", 64'({er2, fs2}), 64'(2'b10));
    tick();
    chk("l2_abort_err_once", 64'(er2), 64'(0));
    // FS whose word count straddles the two header words
    v2 = 1'b1; d2 = 16'h0034; tick();
    chk("l2_fs_hdr0", 64'(fs2), 64'(0));
    d2 = 16'h12EE; tick();
    chk("l2_fs_hdr1", 64'({fs2, fn2, vc2}), 64'({1'b1, 16'h1234, 2'd0}));
    v2 = 1'b0; tick();
    chk("l2_fs_after", 64'({fs2, fn2}), 64'({1'b0, 16'h1234}));

    // ---------------- 1-lane: dropped type, masked VC, then FE ----------------
    bytes = '{8'h2A, 8'h02, 8'h00, 8'hEC, 8'h5A, 8'hA5, 8'hC0, 8'hC1};
    for (int i = 0; i < bytes.size(); i++) begin
      v1 = 1'b1; d1 = bytes[i]; tick();
      chk($sformatf("l1_raw8_%0d", i), 64'({cv1, ck1, cl1}), 64'(0));
    end
    v1 = 1'b0; tick();
    m1 = 4'b0001;
    bytes = '{8'h40, 8'h07, 8'h00, 8'h00};
    for (int i = 0; i < bytes.size(); i++) begin
      v1 = 1'b1; d1 = bytes[i]; tick();
      chk($sformatf("l1_vc1_fs_%0d", i), 64'({fs1, fn1}), 64'(0));
    end
    v1 = 1'b0; tick();
    bytes = '{8'h01, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < bytes.size(); i++) begin
      v1 = 1'b1; d1 = bytes[i]; tick();
      chk($sformatf("l1_fe_%0d", i), 64'(fe1), 64'(i == 3));
    end
    v1 = 1'b0; tick();
    chk("l1_fe_once", 64'(fe1), 64'(0));

    // ---------------- 4-lane: reset in the middle of payload ----------------
    m4 = 4'hF;
    v4 = 1'b1; d4 = 32'h2B100000; tick();
    chk("rst_mid_hdr", 64'(cv4), 64'(0));
    d4 = 32'h12121212; tick();
    chk("rst_mid_p0", 64'({cv4, cd4, ck4}), 64'({1'b1, 32'h12121212, 4'hF}));
    rst = 1'b1; d4 = 32'h34343434; tick();
    chk("rst_mid_zero", act4(), 64'(0));
    rst = 1'b0; d4 = 32'h56565656; tick();
    chk("rst_mid_ignore0", act4(), 64'(0));
    d4 = 32'h78787878; tick();
    chk("rst_mid_ignore1", act4(), 64'(0));
    v4 = 1'b0; tick();
    chk("rst_mid_no_err", act4(), 64'(0));
    v4 = 1'b1; d4 = 32'h00030000; tick();
    chk("rst_mid_next_fs", act4(), 64'({4'b1000, 16'd3, 2'd0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0}));
    v4 = 1'b0; tick();
    chk("rst_mid_fs_once", 64'(fs4), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csi_unpacket_nlane.md
Name: csi_unpacket_nlane

Overview:
Parametrised successor to the fixed 4-lane RAW10 CSI unpacker. It takes the lane-merged HS byte stream from the MIPI RX IP at 1, 2 or 4 lanes and assembles the 32-bit packet header across words when needed. It decodes short packets (frame start/end, line start/end) and forwards long-packet payload for one configurable data type, filtered by virtual channel. Payload is sent downstream as a byte-enabled stream with an end-of-line marker and error flags. The block sits between the MIPI RX IP and the ISP pixel unpacker.

Parameters:
LANES, 4, number of byte lanes (1, 2 or 4); DW = 8*LANES
DATA_DT, 8'h2B, long-packet data type that is forwarded (RAW10); other long types are dropped
HDR_WORDS, 4/LANES (derived, not user-set), words per packet header

Ports:
I_clk  in  1  clock
I_rst  in  1  synchronous active-high reset
I_hs_valid  in  1  RX IP packet-active; high for the whole packet, low between packets
I_hs_data  in  DW  RX IP byte data; earliest byte in bits [DW-1:DW-8]
I_vc_mask  in  4  bit n=1 accepts virtual channel n; sampled at each header decode
O_csi_frame_start  out  1  1-cycle pulse, FS (DT 8'h00) on an accepted VC
O_csi_frame_end  out  1  1-cycle pulse, FE (DT 8'h01) on an accepted VC
O_line_start  out  1  1-cycle pulse, LS (DT 8'h02)
O_line_end  out  1  1-cycle pulse, LE (DT 8'h03)
O_frame_num  out  16  WC field of the last accepted FS
O_vc  out  2  VC of the current/last accepted packet
O_csi_valid  out  1  payload word valid
O_csi_data  out  DW  payload word; unused lanes are 0
O_csi_keep  out  LANES  byte enable; bit i covers bits [8i+7:8i]
O_csi_last  out  1  final payload word of the long packet
O_err_short  out  1  1-cycle pulse, I_hs_valid fell before header/payload complete

Behaviour:
- Reset (synchronous, I_rst=1 at a clock edge): state=IDLE. All outputs 0, including O_frame_num and O_vc. Counters cleared. A packet in progress is abandoned with no error pulse; the next packet is recognised only on a fresh rising edge of I_hs_valid.
- Header byte order: the header is built as {DI, WC_L, WC_H, ECC}. Each header word shifts in MSB-first: hdr <= {hdr[31-DW:0], I_hs_data}. DI=hdr[31:24], VC=DI[7:6], DT=DI[5:0] (DT compared as 8'h00 to 8'h3F), WC={hdr[15:8],hdr[23:16]}. ECC is ignored.
- Start of packet = I_hs_valid & ~valid_1d.
- States:
  - IDLE: on start of packet, load the header word. If HDR_WORDS=1, decode the same cycle; else go to HDR.
  - HDR: shift in words until HDR_WORDS are collected, then decode. If I_hs_valid goes low first, go to IDLE and pulse O_err_short.
  - Decode (same cycle as the last header word):
    - VC not in I_vc_mask -> DRAIN.
    - DT 8'h00..8'h0F (short packet): pulse the matching output on the next cycle. FS also latches O_frame_num=WC and O_vc. Go to DRAIN.
    - DT==DATA_DT and WC>0: latch O_vc, rem=WC, go to PAYLOAD.
    - Any other long DT, or WC==0 -> DRAIN.
  - PAYLOAD: each cycle with I_hs_valid=1 is one payload word.
    - Forward it with one-cycle latency: O_csi_valid=1, O_csi_data=word.
    - While rem>LANES: keep=all 1s and rem-=LANES.
    - When rem<=LANES: keep = the top rem bits set (LANES=4, rem=1 -> 4'b1000), data in masked-off lanes forced to 0, O_csi_last=1, go to DRAIN.
    - If I_hs_valid goes low with rem>0: go to IDLE, pulse O_err_short, emit no O_csi_last.
  - DRAIN: discard words (CRC/trailer/filler) until I_hs_valid=0, then IDLE.
- Back-to-back packets: valid low for exactly one cycle then high is a new start of packet.
- rem is 17 bits; WC=16'hFFFF is handled without overflow.
- Latency: every output is registered; all pulses appear one cycle after the triggering input word.
- O_csi_valid is 0 outside PAYLOAD output cycles; O_csi_data=0 and O_csi_keep=0 whenever O_csi_valid=0.

Decomposition:
- Shared package csi_pkg holds:
  - DT constants: DT_FS=8'h00, DT_FE=8'h01, DT_LS=8'h02, DT_LE=8'h03, DT_RAW8=8'h2A, DT_RAW10=8'h2B, DT_RAW12=8'h2C.
  - The short-packet range limit 8'h0F.
  - The state enum {IDLE, HDR, PAYLOAD, DRAIN}.
- One sub-module, csi_hdr_collect: start-of-packet detection, multi-word header shift register, hdr_done strobe and field extraction (vc, dt, wc). The FSM, payload counter and keep generation stay in the top level.

Test Plan:
- LANES=4, I_vc_mask=4'hF, FS with WC=16'h0007 -> O_csi_frame_start pulses once 1 cycle after the header word; O_frame_num=7, O_vc=0.
- LANES=4, RAW10 long packet, WC=10, then 3 payload words and 2 CRC bytes -> 3 valid words with keep 4'hF, 4'hF, 4'b1100; O_csi_last on the third; CRC not forwarded.
- LANES=2, RAW10 WC=5 over 2 header words + 3 payload words -> keep 2'b11, 2'b11, 2'b10; last on the third; header split decoded correctly.
- LANES=1, long packet DT=8'h2A (not DATA_DT), then a VC=1 FS with I_vc_mask=4'b0001 -> no O_csi_valid and no frame_start; the next VC=0 FE still pulses.
- LANES=4, RAW10 WC=16 with I_hs_valid dropped after 2 payload words -> 2 valid words, no O_csi_last, O_err_short pulses once; next packet after a 1-cycle gap decodes normally.
- Assert I_rst mid-PAYLOAD -> all outputs 0 next cycle, no error pulse; remaining words of that packet ignored until I_hs_valid falls and rises again.
